// File: rtl/tile_select_sender_if.sv
// Tile offer handshake between the select-input producer and the game FSM.
// The sender drives the offer; the FSM returns tileAck.
interface tile_select_sender_if;
  logic        tileValid;
  logic [3:0]  tileIdx;
  logic [10:0] tileCode;
  logic        tileAck;

  modport master (output tileValid, output tileIdx, output tileCode, input tileAck);
  modport slave  (input tileValid, input tileIdx, input tileCode, output tileAck);
endinterface

// File: rtl/tile_select_sender.sv
// Debounced select key + tile switches -> one validated tile offer per press.
// Optional STRICT_ONEHOT_EN: reject presses with more than one switch up.
module tile_select_sender #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                         CLOCK_50,
  input  logic                         clear,
  input  logic                         selectKEY,
  input  logic [9:0]                   SW,
  input  logic [9:0]                   pastOn,
  tile_select_sender_if.master         tile_if,
  output logic                         reject,
  output logic                         busy
);

  localparam logic [23:0] DbMax = 24'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StCheck, StOffer, StReject} state_e;

  logic        key_meta_q, key_sync_q;
  logic [9:0]  sw_meta_q, sw_sync_q;
  logic        key_db_q, key_db_d, key_db_prev_q;
  logic [23:0] db_cnt_q, db_cnt_d;
  logic        press_q, press_d;
  logic [1:0]  settle_q, settle_d;
  logic        armed_q, armed_d;
  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [10:0] code_q, code_d;

  logic [3:0]  low_idx;
  logic        sw_multi;

  function automatic logic [5:0] colour_of(input logic [3:0] i);
    case (i)
      4'd0, 4'd7: colour_of = 6'd1;
      4'd1, 4'd4: colour_of = 6'd2;
      4'd2, 4'd6: colour_of = 6'd3;
      4'd3, 4'd5: colour_of = 6'd4;
      4'd8, 4'd9: colour_of = 6'd5;
      default:    colour_of = 6'd0;
    endcase
  endfunction

  always_ff @(posedge CLOCK_50 or negedge clear) begin
    if (!clear) begin
      key_meta_q    <= 1'b1;
      key_sync_q    <= 1'b1;
      sw_meta_q     <= '0;
      sw_sync_q     <= '0;
      key_db_q      <= 1'b1;
      key_db_prev_q <= 1'b1;
      db_cnt_q      <= '0;
      press_q       <= 1'b0;
      settle_q      <= '0;
      armed_q       <= 1'b0;
      state_q       <= StIdle;
      idx_q         <= '0;
      code_q        <= '0;
    end else begin
      key_meta_q    <= selectKEY;
      key_sync_q    <= key_meta_q;
      sw_meta_q     <= SW;
      sw_sync_q     <= sw_meta_q;
      key_db_q      <= key_db_d;
      key_db_prev_q <= key_db_q;
      db_cnt_q      <= db_cnt_d;
      press_q       <= press_d;
      settle_q      <= settle_d;
      armed_q       <= armed_d;
      state_q       <= state_d;
      idx_q         <= idx_d;
      code_q        <= code_d;
    end
  end

  always_comb begin
    key_db_d = key_db_q;
    db_cnt_d = '0;
    if (key_sync_q != key_db_q) begin
      if (db_cnt_q == DbMax) begin
        key_db_d = ~key_db_q;
      end else begin
        db_cnt_d = db_cnt_q + 24'd1;
      end
    end
  end

  // A key already held through reset must be seen released before it can
  // generate a press; settle_q waits out the synchronizer reset values.
  always_comb begin
    settle_d = {settle_q[0], 1'b1};
    armed_d  = armed_q | (settle_q[1] & key_sync_q & key_db_q);
    press_d  = armed_q & key_db_prev_q & ~key_db_q;
  end

  always_comb begin
    low_idx = '0;
    for (int i = 9; i >= 0; i--) begin
      if (sw_sync_q[i]) low_idx = 4'(i);
    end
    sw_multi = (sw_sync_q & (sw_sync_q - 10'd1)) != '0;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    code_d  = code_q;
    unique case (state_q)
      StIdle: if (press_q) state_d = StCheck;
      StCheck: begin
        if (sw_sync_q == '0 || pastOn[low_idx]) begin
          state_d = StReject;
`ifdef STRICT_ONEHOT_EN
        end else if (sw_multi) begin
          state_d = StReject;
`endif
        end else begin
          idx_d   = low_idx;
          code_d  = {low_idx[3:2], low_idx[1:0], colour_of(low_idx), 1'b1};
          state_d = StOffer;
        end
      end
      StOffer:  if (tile_if.tileAck) state_d = StIdle;
      StReject: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    tile_if.tileValid = (state_q == StOffer);
    tile_if.tileIdx   = idx_q;
    tile_if.tileCode  = code_q;
    reject            = (state_q == StReject);
    busy              = (state_q != StIdle);
  end

  // sw_multi only feeds the strict-onehot build.
  logic unused_multi;
  assign unused_multi = sw_multi;

endmodule

// File: tb/tb_tile_select_sender.sv
// Directed self-checking bench for tile_select_sender with DEBOUNCE_CYCLES=4.
module tb_tile_select_sender;

  logic       CLOCK_50 = 1'b0;
  logic       clear = 1'b0;
  logic       selectKEY = 1'b1;
  logic [9:0] SW = '0;
  logic [9:0] pastOn = '0;
  logic       reject, busy;

  int tests = 0;
  int fails = 0;
  int valid_cnt, rej_cnt, busy_cnt;
  logic [3:0]  last_idx;
  logic [10:0] last_code;

  tile_select_sender_if tif ();

  tile_select_sender #(.DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50 (CLOCK_50),
    .clear    (clear),
    .selectKEY(selectKEY),
    .SW       (SW),
    .pastOn   (pastOn),
    .tile_if  (tif),
    .reject   (reject),
    .busy     (busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic clr_cnt();
    valid_cnt = 0;
    rej_cnt   = 0;
    busy_cnt  = 0;
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLOCK_50);
      #1;
      if (tif.tileValid) begin
        valid_cnt++;
        last_idx  = tif.tileIdx;
        last_code = tif.tileCode;
      end
      if (reject) rej_cnt++;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic press();
    @(negedge CLOCK_50);
    selectKEY = 1'b0;
  endtask

  task automatic release_key();
    @(negedge CLOCK_50);
    selectKEY = 1'b1;
    repeat (12) @(posedge CLOCK_50);
  endtask

  task automatic wait_valid(input string name);
    bit ok = 0;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(posedge CLOCK_50);
      #1;
      if (tif.tileValid) ok = 1;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: tileValid=0 after 30 cycles, required 1", name);
    end
  endtask

  task automatic ack_offer(input string name);
    @(negedge CLOCK_50);
    tif.tileAck = 1'b1;
    @(posedge CLOCK_50);
    #1;
    tests++;
    if (tif.tileValid !== 1'b0) begin
      fails++;
      $display("FAIL %s: tileValid=%b after ack, required 0", name, tif.tileValid);
    end
    @(negedge CLOCK_50);
    tif.tileAck = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b0; selectKEY = 1'b0; SW = 10'h3FF; pastOn = '0; tif.tileAck = 1'b0;
    #23;
    tests++; if (tif.tileValid !== 1'b0) begin fails++;
      $display("FAIL reset_valid: got %b required 0", tif.tileValid); end
    tests++; if (tif.tileIdx !== 4'd0) begin fails++;
      $display("FAIL reset_idx: got %0d required 0", tif.tileIdx); end
    tests++; if (tif.tileCode !== 11'd0) begin fails++;
      $display("FAIL reset_code: got %b required 0", tif.tileCode); end
    tests++; if (reject !== 1'b0) begin fails++;
      $display("FAIL reset_reject: got %b required 0", reject); end
    tests++; if (busy !== 1'b0) begin fails++;
      $display("FAIL reset_busy: got %b required 0", busy); end
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    clear = 1'b1;
    clr_cnt();
    cyc(20);
    tests++; if (busy_cnt != 0) begin fails++;
      $display("FAIL reset_held_key: busy for %0d cycles, required 0", busy_cnt); end
    release_key();
    press();
    wait_valid("reset_rearm_valid");
    tests++; if (tif.tileCode !== 11'b00_00_000001_1) begin fails++;
      $display("FAIL reset_rearm_code: got %b required 00000000011", tif.tileCode); end
    ack_offer("reset_rearm_ack");
    release_key();
  endtask

  task automatic test_clean_press();
    int stable = 0;
    SW = 10'b0000100000; pastOn = '0;
    press();
    repeat (8) @(posedge CLOCK_50);
    #1;
    tests++; if (tif.tileValid !== 1'b0) begin fails++;
      $display("FAIL clean_early: tileValid=%b one cycle before D+3, required 0", tif.tileValid); end
    @(posedge CLOCK_50);
    #1;
    tests++; if (tif.tileValid !== 1'b1) begin fails++;
      $display("FAIL clean_latency: tileValid=%b at D+3, required 1", tif.tileValid); end
    tests++; if (tif.tileIdx !== 4'd5) begin fails++;
      $display("FAIL clean_idx: got %0d required 5", tif.tileIdx); end
    tests++; if (tif.tileCode !== 11'b01_01_000100_1) begin fails++;
      $display("FAIL clean_code: got %b required 01010001001", tif.tileCode); end
    @(negedge CLOCK_50);
    SW = 10'b0000000001; // must not disturb the pending offer
    for (int k = 0; k < 10; k++) begin
      @(posedge CLOCK_50);
      #1;
      if (tif.tileValid && tif.tileIdx == 4'd5 && tif.tileCode == 11'b01_01_000100_1) stable++;
    end
    tests++; if (stable != 10) begin fails++;
      $display("FAIL clean_hold: stable %0d cycles, required 10", stable); end
    ack_offer("clean_ack");
    clr_cnt();
    cyc(15);
    tests++; if (valid_cnt != 0) begin fails++;
      $display("FAIL clean_held_once: %0d extra offer cycles, required 0", valid_cnt); end
    release_key();
  endtask

  task automatic test_bounce();
    SW = 10'b0000000010; tif.tileAck = 1'b1;
    clr_cnt();
    for (int b = 0; b < 3; b++) begin
      @(negedge CLOCK_50); selectKEY = 1'b0; cyc(3);
      @(negedge CLOCK_50); selectKEY = 1'b1; cyc(3);
    end
    @(negedge CLOCK_50); selectKEY = 1'b0;
    cyc(30);
    tests++; if (valid_cnt != 1) begin fails++;
      $display("FAIL bounce_count: %0d offers, required 1", valid_cnt); end
    tests++; if (last_code !== 11'b00_01_000010_1) begin fails++;
      $display("FAIL bounce_code: got %b required 00010000101", last_code); end
    tif.tileAck = 1'b0;
    release_key();
  endtask

  task automatic test_rejects();
    SW = '0; pastOn = '0;
    clr_cnt(); press(); cyc(20);
    tests++; if (rej_cnt != 1 || valid_cnt != 0) begin fails++;
      $display("FAIL reject_zero: reject=%0d valid=%0d, required 1/0", rej_cnt, valid_cnt); end
    release_key();
    SW = 10'b0000000100; pastOn = 10'b0000000100;
    clr_cnt(); press(); cyc(20);
    tests++; if (rej_cnt != 1 || valid_cnt != 0) begin fails++;
      $display("FAIL reject_past_on: reject=%0d valid=%0d, required 1/0", rej_cnt, valid_cnt); end
    release_key();
    pastOn = '0;
  endtask

  task automatic test_priority();
    SW = 10'b1000001000; tif.tileAck = 1'b1;
    clr_cnt(); press(); cyc(20);
`ifdef STRICT_ONEHOT_EN
    tests++; if (rej_cnt != 1 || valid_cnt != 0) begin fails++;
      $display("FAIL strict_multi: reject=%0d valid=%0d, required 1/0", rej_cnt, valid_cnt); end
`else
    tests++; if (valid_cnt != 1 || last_idx !== 4'd3) begin fails++;
      $display("FAIL priority_idx: valid=%0d idx=%0d, required 1/3", valid_cnt, last_idx); end
    tests++; if (last_code !== 11'b00_11_000100_1) begin fails++;
      $display("FAIL priority_code: got %b required 00110001001", last_code); end
`endif
    tif.tileAck = 1'b0;
    release_key();
  endtask

  task automatic test_dropped_press();
    SW = 10'b0000010000;
    press();
    wait_valid("drop_first_valid");
    @(negedge CLOCK_50); selectKEY = 1'b1;
    clr_cnt(); cyc(10);
    @(negedge CLOCK_50); selectKEY = 1'b0;
    cyc(12);
    tests++; if (valid_cnt != 22 || rej_cnt != 0) begin fails++;
      $display("FAIL drop_hold: valid=%0d reject=%0d, required 22/0", valid_cnt, rej_cnt); end
    tests++; if (last_code !== 11'b01_00_000010_1) begin fails++;
      $display("FAIL drop_code: got %b required 01000000101", last_code); end
    ack_offer("drop_ack");
    clr_cnt(); cyc(20);
    tests++; if (valid_cnt != 0 || busy_cnt != 0) begin fails++;
      $display("FAIL drop_queued: valid=%0d busy=%0d, required 0/0", valid_cnt, busy_cnt); end
    release_key();
    press();
    wait_valid("midreset_valid");
    @(negedge CLOCK_50);
    #2 clear = 1'b0;
    #1;
    tests++; if (tif.tileValid !== 1'b0 || busy !== 1'b0) begin fails++;
      $display("FAIL midreset_async: valid=%b busy=%b, required 0/0", tif.tileValid, busy); end
    @(negedge CLOCK_50);
    clear = 1'b1;
    release_key();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_rejects();
    test_priority();
    test_dropped_press();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
